device_cmd_controller: RTL and testbench

DEVICE_CMD_CONTROLLER -- requirements
Module: device_cmd_controller

---
 rtl/device_cmd_controller_if.sv | 13 +
 rtl/device_cmd_controller.sv | 269 ++++++++++++++++++++++++++
 tb/tb_device_cmd_controller.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/device_cmd_controller_if.sv
// Memory write-request bus: the controller (master) presents address/data/valid, memory (slave) answers with fifo_full_mem backpressure.
interface device_cmd_controller_if #(
  parameter int unsigned ADDRESS_WIDTH = 25,
  parameter int unsigned DATA_WIDTH    = 16
);
  logic [ADDRESS_WIDTH-1:0] address_mem;
  logic [DATA_WIDTH-1:0]    data_out_mem;
  logic                     data_out_valid_mem;
  logic                     fifo_full_mem;

  modport master (output address_mem, data_out_mem, data_out_valid_mem, input fifo_full_mem);
  modport slave  (input address_mem, data_out_mem, data_out_valid_mem, output fifo_full_mem);
endinterface

// File: rtl/device_cmd_controller.sv
// Byte-stream command decoder feeding a memory write queue and panel configuration registers.
// Optional macro DEVICE_CMD_DROP_COUNT_EN adds a saturating drop_count output.
module device_cmd_controller #(
  parameter int unsigned ADDRESS_WIDTH = 25,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned ADDR_BYTES    = 4
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    cs_n,
  input  logic [7:0]              data_in,
  input  logic                    data_in_ready,
  device_cmd_controller_if.master mem,
  output logic                    frame_buffer_select,
  output logic                    color_format,
  output logic [9:0]              pixels_per_row,
  output logic [3:0]              panel_rows,
  output logic                    overflow,
  output logic                    busy
`ifdef DEVICE_CMD_DROP_COUNT_EN
  ,
  output logic [15:0]             drop_count
`endif
);

  localparam int unsigned BPW   = DATA_WIDTH / 8;
  localparam int unsigned BCW   = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ASM_W = (ADDR_BYTES * 8 > ADDRESS_WIDTH) ? ADDR_BYTES * 8 : ADDRESS_WIDTH;
  localparam int unsigned ABC_W = $clog2(ADDR_BYTES) + 1;

  localparam logic [7:0] CMD_WRITE = 8'h10;
  localparam logic [7:0] CMD_FLIP  = 8'h20;
  localparam logic [7:0] CMD_COLOR = 8'h30;
  localparam logic [7:0] CMD_PPR   = 8'h40;
  localparam logic [7:0] CMD_ROWS  = 8'h50;
  localparam logic [7:0] CMD_CLEAR = 8'h60;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_PAYLOAD, S_WRITE_DATA, S_DONE} state_e;

  state_e                   state_q, state_d;
  logic [1:0]               cs_sync_q;
  logic [7:0]               cmd_q, cmd_d;
  logic [ABC_W-1:0]         abyte_cnt_q, abyte_cnt_d;
  logic [ASM_W-1:0]         addr_asm_q, addr_asm_d;
  logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [BCW-1:0]           wbyte_cnt_q, wbyte_cnt_d;
  logic [DATA_WIDTH-1:0]    word_asm_q, word_asm_d;
  logic                     pay_cnt_q, pay_cnt_d;
  logic [7:0]               pay0_q, pay0_d;
  logic                     fbs_q, fbs_d, cf_q, cf_d;
  logic [9:0]               ppr_q, ppr_d;
  logic [3:0]               rows_q, rows_d;
  logic                     ovf_q, ovf_d, busy_q, busy_d;

  logic                     cs_n_s, byte_v;
  logic                     push_c, clear_status_c;
  logic [DATA_WIDTH-1:0]    push_word_c;

  logic [ADDRESS_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     out_valid_q, out_valid_d;
  logic [ADDRESS_WIDTH-1:0] out_addr_q, out_addr_d;
  logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
  logic                     pop_c, push_ok_c, drop_c;

  assign cs_n_s = cs_sync_q[1];
  assign byte_v = data_in_ready && !cs_n_s;

  // Command decode; deselect always returns to IDLE and any partial address/word is simply abandoned.
  always_comb begin
    state_d        = state_q;
    cmd_d          = cmd_q;
    abyte_cnt_d    = abyte_cnt_q;
    addr_asm_d     = addr_asm_q;
    wr_addr_d      = wr_addr_q;
    wbyte_cnt_d    = wbyte_cnt_q;
    word_asm_d     = word_asm_q;
    pay_cnt_d      = pay_cnt_q;
    pay0_d         = pay0_q;
    fbs_d          = fbs_q;
    cf_d           = cf_q;
    ppr_d          = ppr_q;
    rows_d         = rows_q;
    push_c         = 1'b0;
    push_word_c    = '0;
    clear_status_c = 1'b0;
    if (cs_n_s) begin
      state_d = S_IDLE;
    end else if (byte_v) begin
      case (state_q)
        S_IDLE: begin
          cmd_d       = data_in;
          abyte_cnt_d = '0;
          addr_asm_d  = '0;
          pay_cnt_d   = 1'b0;
          case (data_in)
            CMD_WRITE:                              state_d = S_ADDR;
            CMD_FLIP, CMD_COLOR, CMD_PPR, CMD_ROWS: state_d = S_PAYLOAD;
            CMD_CLEAR: begin
              clear_status_c = 1'b1;
              state_d        = S_DONE;
            end
            default:                                state_d = S_DONE;
          endcase
        end
        S_ADDR: begin
          addr_asm_d  = ASM_W'({addr_asm_q, data_in});
          abyte_cnt_d = abyte_cnt_q + ABC_W'(1);
          if (abyte_cnt_q == ABC_W'(ADDR_BYTES - 1)) begin
            wr_addr_d   = addr_asm_d[ADDRESS_WIDTH-1:0];
            wbyte_cnt_d = '0;
            word_asm_d  = '0;
            state_d     = S_WRITE_DATA;
          end
        end
        S_WRITE_DATA: begin
          if (!cf_q) begin
            push_c      = 1'b1;
            push_word_c = DATA_WIDTH'(data_in);
          end else begin
            word_asm_d = DATA_WIDTH'({word_asm_q, data_in});
            if (wbyte_cnt_q == BCW'(BPW - 1)) begin
              push_c      = 1'b1;
              push_word_c = word_asm_d;
              wbyte_cnt_d = '0;
            end else begin
              wbyte_cnt_d = wbyte_cnt_q + BCW'(1);
            end
          end
          if (push_c) wr_addr_d = wr_addr_q + ADDRESS_WIDTH'(1);
        end
        S_PAYLOAD: begin
          pay0_d    = data_in;
          pay_cnt_d = 1'b1;
          if (!(cmd_q == CMD_PPR && !pay_cnt_q)) begin
            state_d = S_DONE;
            case (cmd_q)
              CMD_FLIP:  fbs_d  = data_in[0];
              CMD_COLOR: cf_d   = data_in[0];
              CMD_PPR:   ppr_d  = {pay0_q[1:0], data_in};
              CMD_ROWS:  rows_d = data_in[3:0];
              default:   ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  // Queue with a registered head: count includes the word being presented to memory.
  always_comb begin
    pop_c       = out_valid_q && !mem.fifo_full_mem;
    push_ok_c   = push_c && ((count_q != CNT_W'(FIFO_DEPTH)) || pop_c);
    drop_c      = push_c && !push_ok_c;
    count_d     = count_q + CNT_W'(push_ok_c) - CNT_W'(pop_c);
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop_c);
    wr_ptr_d    = wr_ptr_q + PTR_W'(push_ok_c);
    out_valid_d = (count_d != '0);
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    if ((count_q - CNT_W'(pop_c)) == '0) begin
      if (push_ok_c) begin
        out_addr_d = wr_addr_q;
        out_data_d = push_word_c;
      end
    end else begin
      out_addr_d = fifo_addr_q[rd_ptr_d];
      out_data_d = fifo_data_q[rd_ptr_d];
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (clear_status_c)  ovf_d = 1'b0;
    else if (drop_c)     ovf_d = 1'b1;
    busy_d = (state_d != S_IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk_sys) begin
    if (push_ok_c) begin
      fifo_addr_q[wr_ptr_q] <= wr_addr_q;
      fifo_data_q[wr_ptr_q] <= push_word_c;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cs_sync_q   <= 2'b11;
      cmd_q       <= '0;
      abyte_cnt_q <= '0;
      addr_asm_q  <= '0;
      wr_addr_q   <= '0;
      wbyte_cnt_q <= '0;
      word_asm_q  <= '0;
      pay_cnt_q   <= 1'b0;
      pay0_q      <= '0;
      fbs_q       <= 1'b0;
      cf_q        <= 1'b0;
      ppr_q       <= 10'd10;
      rows_q      <= 4'd1;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cs_sync_q   <= {cs_sync_q[0], cs_n};
      cmd_q       <= cmd_d;
      abyte_cnt_q <= abyte_cnt_d;
      addr_asm_q  <= addr_asm_d;
      wr_addr_q   <= wr_addr_d;
      wbyte_cnt_q <= wbyte_cnt_d;
      word_asm_q  <= word_asm_d;
      pay_cnt_q   <= pay_cnt_d;
      pay0_q      <= pay0_d;
      fbs_q       <= fbs_d;
      cf_q        <= cf_d;
      ppr_q       <= ppr_d;
      rows_q      <= rows_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef DEVICE_CMD_DROP_COUNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clear_status_c)                         drop_cnt_d = '0;
    else if (drop_c && drop_cnt_q != 16'hFFFF)  drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`endif

  assign mem.address_mem        = out_addr_q;
  assign mem.data_out_mem       = out_data_q;
  assign mem.data_out_valid_mem = out_valid_q;
  assign frame_buffer_select    = fbs_q;
  assign color_format           = cf_q;
  assign pixels_per_row         = ppr_q;
  assign panel_rows             = rows_q;
  assign overflow               = ovf_q;
  assign busy                   = busy_q;

endmodule

// File: tb/tb_device_cmd_controller.sv
// Directed bench for device_cmd_controller: register-command vector table plus hand-written write/overflow/reset sequences.
module tb_device_cmd_controller;

  localparam int unsigned AW    = 25;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 8;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       cs_n;
  logic [7:0] data_in;
  logic       data_in_ready;
  logic       frame_buffer_select, color_format, overflow, busy;
  logic [9:0] pixels_per_row;
  logic [3:0] panel_rows;
`ifdef DEVICE_CMD_DROP_COUNT_EN
  logic [15:0] drop_count;
`endif

  device_cmd_controller_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

  device_cmd_controller #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ADDR_BYTES(4)
  ) dut (
    .clk_sys             (clk_sys),
    .reset               (reset),
    .cs_n                (cs_n),
    .data_in             (data_in),
    .data_in_ready       (data_in_ready),
    .mem                 (mem_if),
    .frame_buffer_select (frame_buffer_select),
    .color_format        (color_format),
    .pixels_per_row      (pixels_per_row),
    .panel_rows          (panel_rows),
    .overflow            (overflow),
    .busy                (busy)
`ifdef DEVICE_CMD_DROP_COUNT_EN
    ,
    .drop_count          (drop_count)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] log_addr [$];
  logic [DW-1:0] log_data [$];
  logic [7:0]    frame_q  [$];

  // Accepted memory writes: valid with no backpressure means a pop on the coming edge.
  always @(negedge clk_sys) begin
    if (!reset && mem_if.data_out_valid_mem && !mem_if.fifo_full_mem) begin
      log_addr.push_back(mem_if.address_mem);
      log_data.push_back(mem_if.data_out_mem);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_frame();
    cs_n = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
  endtask

  task automatic end_frame();
    @(posedge clk_sys);
    #1;
    cs_n = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    data_in       = b;
    data_in_ready = 1'b1;
    @(posedge clk_sys);
    #1;
    data_in_ready = 1'b0;
  endtask

  task automatic send_frame();
    start_frame();
    foreach (frame_q[i]) send_byte(frame_q[i]);
    end_frame();
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 300 && busy; k++) @(negedge clk_sys);
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic check_log(input int n, input logic [AW-1:0] a0, input logic [DW-1:0] d0);
    check("write_count", 32'(log_addr.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < log_addr.size()) begin
        check("write_addr", 32'(log_addr[i]), 32'(a0 + AW'(i)));
        check("write_data", 32'(log_data[i]), 32'(d0 + DW'(i)));
      end
    end
    log_addr.delete();
    log_data.delete();
  endtask

  typedef struct {
    logic [31:0] bytes;
    int          n;
    logic        fbs;
    logic        cf;
    logic [9:0]  ppr;
    logic [3:0]  rows;
  } reg_vec_t;

  reg_vec_t vecs [10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h4002_8000, 3, 1'b0, 1'b0, 10'd640,  4'd1};
    vecs[1] = '{32'h500F_0000, 2, 1'b0, 1'b0, 10'd640,  4'd15};
    vecs[2] = '{32'h2001_0000, 2, 1'b1, 1'b0, 10'd640,  4'd15};
    vecs[3] = '{32'h7755_0000, 2, 1'b1, 1'b0, 10'd640,  4'd15};
    vecs[4] = '{32'h3001_0000, 2, 1'b1, 1'b1, 10'd640,  4'd15};
    vecs[5] = '{32'h3000_0000, 2, 1'b1, 1'b0, 10'd640,  4'd15};
    vecs[6] = '{32'h4001_0000, 2, 1'b1, 1'b0, 10'd640,  4'd15};
    vecs[7] = '{32'h20FE_0000, 2, 1'b0, 1'b0, 10'd640,  4'd15};
    vecs[8] = '{32'h50A3_9900, 3, 1'b0, 1'b0, 10'd640,  4'd3};
    vecs[9] = '{32'h4003_FF00, 3, 1'b0, 1'b0, 10'd1023, 4'd3};

    reset = 1'b1; cs_n = 1'b1; data_in = '0; data_in_ready = 1'b0;
    mem_if.fifo_full_mem = 1'b0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check("rst_valid", 32'(mem_if.data_out_valid_mem), 32'd0);
    check("rst_addr",  32'(mem_if.address_mem), 32'd0);
    check("rst_data",  32'(mem_if.data_out_mem), 32'd0);
    check("rst_fbs",   32'(frame_buffer_select), 32'd0);
    check("rst_cf",    32'(color_format), 32'd0);
    check("rst_ppr",   32'(pixels_per_row), 32'd10);
    check("rst_rows",  32'(panel_rows), 32'd1);
    check("rst_ovf",   32'(overflow), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;

    // Register commands, state carried from vector to vector.
    for (int v = 0; v < 10; v++) begin
      start_frame();
      for (int i = 0; i < vecs[v].n; i++) send_byte(vecs[v].bytes[31 - 8 * i -: 8]);
      end_frame();
      check("vec_fbs",  32'(frame_buffer_select), 32'(vecs[v].fbs));
      check("vec_cf",   32'(color_format), 32'(vecs[v].cf));
      check("vec_ppr",  32'(pixels_per_row), 32'(vecs[v].ppr));
      check("vec_rows", 32'(panel_rows), 32'(vecs[v].rows));
    end

    // Update lands on the edge that captures the final payload byte.
    start_frame();
    send_byte(8'h20);
    data_in = 8'h01; data_in_ready = 1'b1;
    @(negedge clk_sys);
    check("flip_before", 32'(frame_buffer_select), 32'd0);
    @(posedge clk_sys); #1; data_in_ready = 1'b0;
    @(negedge clk_sys);
    check("flip_after", 32'(frame_buffer_select), 32'd1);
    end_frame();

    // Byte-per-word writes, first-word latency, back-to-back push/pop at single occupancy.
    start_frame();
    send_byte(8'h10); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
    @(negedge clk_sys);
    check("wr_novalid", 32'(mem_if.data_out_valid_mem), 32'd0);
    send_byte(8'hAA);
    @(negedge clk_sys);
    check("wr_lat_valid", 32'(mem_if.data_out_valid_mem), 32'd1);
    check("wr_lat_addr",  32'(mem_if.address_mem), 32'h100);
    check("wr_lat_data",  32'(mem_if.data_out_mem), 32'h00AA);
    send_byte(8'hBB);
    end_frame();
    wait_idle();
    check("wr_n", 32'(log_addr.size()), 32'd2);
    if (log_addr.size() == 2) begin
      check("wr0_addr", 32'(log_addr[0]), 32'h100);
      check("wr0_data", 32'(log_data[0]), 32'h00AA);
      check("wr1_addr", 32'(log_addr[1]), 32'h101);
      check("wr1_data", 32'(log_data[1]), 32'h00BB);
    end
    log_addr.delete(); log_data.delete();

    // Packed words; trailing half word must not leak into the next frame.
    frame_q = '{8'h30, 8'h01}; send_frame();
    check("cf_set", 32'(color_format), 32'd1);
    frame_q = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h05, 8'h12, 8'h34, 8'h56}; send_frame();
    wait_idle();
    check_log(1, 25'h5, 16'h1234);
    frame_q = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h09, 8'hAB, 8'hCD}; send_frame();
    wait_idle();
    check_log(1, 25'h9, 16'hABCD);
    frame_q = '{8'h30, 8'h00}; send_frame();

    // Backpressure: FIFO_DEPTH+2 bytes, two dropped, head held steady.
    mem_if.fifo_full_mem = 1'b1;
    start_frame();
    send_byte(8'h10); send_byte(8'h00); send_byte(8'h00); send_byte(8'h02); send_byte(8'h00);
    for (int i = 0; i < DEPTH + 2; i++) send_byte(8'(8'h10 + i));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_sys);
      check("bp_valid", 32'(mem_if.data_out_valid_mem), 32'd1);
      check("bp_addr",  32'(mem_if.address_mem), 32'h200);
      check("bp_data",  32'(mem_if.data_out_mem), 32'h0010);
    end
    check("bp_ovf", 32'(overflow), 32'd1);
`ifdef DEVICE_CMD_DROP_COUNT_EN
    check("bp_drops", 32'(drop_count), 32'd2);
`endif
    end_frame();
    mem_if.fifo_full_mem = 1'b0;
    wait_idle();
    check_log(DEPTH, 25'h200, 16'h0010);
    check("ovf_sticky", 32'(overflow), 32'd1);
    start_frame();
    send_byte(8'h60);
    @(negedge clk_sys);
    check("ovf_clear", 32'(overflow), 32'd0);
`ifdef DEVICE_CMD_DROP_COUNT_EN
    check("drops_clear", 32'(drop_count), 32'd0);
`endif
    end_frame();

    // Reset mid-frame with three words queued behind backpressure.
    mem_if.fifo_full_mem = 1'b1;
    frame_q = '{8'h50, 8'h07}; send_frame();
    start_frame();
    send_byte(8'h10); send_byte(8'h00); send_byte(8'h00); send_byte(8'h03); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    @(negedge clk_sys);
    check("pre_rst_valid", 32'(mem_if.data_out_valid_mem), 32'd1);
    reset = 1'b1;
    #1;
    check("rst2_valid", 32'(mem_if.data_out_valid_mem), 32'd0);
    check("rst2_addr",  32'(mem_if.address_mem), 32'd0);
    check("rst2_data",  32'(mem_if.data_out_mem), 32'd0);
    check("rst2_rows",  32'(panel_rows), 32'd1);
    check("rst2_busy",  32'(busy), 32'd0);
    log_addr.delete(); log_data.delete();
    @(posedge clk_sys); #1;
    mem_if.fifo_full_mem = 1'b0;
    reset = 1'b0;
    repeat (20) @(posedge clk_sys);
    @(negedge clk_sys);
    check("post_rst_writes", 32'(log_addr.size()), 32'd0);
    check("post_rst_valid",  32'(mem_if.data_out_valid_mem), 32'd0);
    cs_n = 1'b1;
    repeat (3) @(posedge clk_sys);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
